// File: rtl/l2_ram_pkg.sv
// Shared types and defaults for the multi-bank L2 RAM controller.
package l2_ram_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_INIT  = 2'd2
   } l2_state_e;

   localparam logic [31:0] L2_IL_BASE_ADDR   = 32'h1C00_0000;
   localparam logic [31:0] L2_PRIV_BASE_ADDR = 32'h1C08_0000;
   localparam logic [31:0] L2_ERR_RDATA      = 32'hBADA_CCE5;

   // Widths for the default 4 x 32768-word configuration.
   localparam int unsigned BANK_AW = 15;
   localparam int unsigned SEL_W   = 2;

   function automatic int unsigned bank_aw(input int unsigned words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

   function automatic int unsigned sel_w(input int unsigned banks);
      return (banks > 1) ? $clog2(banks) : 0;
   endfunction

endpackage

// File: rtl/l2_bank_resp_pipe.sv
// Per-bank response tracker: one {valid, err, is_read} entry per grant, delivered LATENCY cycles later.
module l2_bank_resp_pipe
   import l2_ram_pkg::*;
#(
   parameter int unsigned LATENCY = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic valid_i,
   input  logic err_i,
   input  logic is_read_i,
   output logic valid_o,
   output logic err_o,
   output logic is_read_o,
   output logic empty_o
);

   logic [LATENCY-1:0] valid_q;
   logic [LATENCY-1:0] err_q;
   logic [LATENCY-1:0] rd_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else begin
         valid_q[0] <= valid_i;
         for (int i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
      end
   end

   // Payload bits are qualified by valid, so they need no reset.
   always_ff @(posedge clk_i) begin
      err_q[0] <= err_i;
      rd_q[0]  <= is_read_i;
      for (int i = 1; i < LATENCY; i++) begin
         err_q[i] <= err_q[i-1];
         rd_q[i]  <= rd_q[i-1];
      end
   end

   assign valid_o   = valid_q[LATENCY-1];
   assign err_o     = err_q[LATENCY-1];
   assign is_read_o = rd_q[LATENCY-1];
   assign empty_o   = ~|valid_q;

endmodule

// File: rtl/tc_sram.sv
// Behavioural single-port SRAM macro with byte enables and configurable read latency.
module tc_sram #(
   parameter int unsigned NumWords  = 1024,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned ByteWidth = 8,
   parameter int unsigned Latency   = 1,
   localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
   localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
   input  logic                 clk_i,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [DataWidth-1:0] wdata_i,
   input  logic [BeWidth-1:0]   be_i,
   output logic [DataWidth-1:0] rdata_o
);

   logic [DataWidth-1:0] mem_q   [NumWords];
   logic [DataWidth-1:0] rdata_q [Latency];

   always_ff @(posedge clk_i) begin
      if (req_i && we_i) begin
         for (int b = 0; b < BeWidth; b++) begin
            if (be_i[b]) mem_q[addr_i][b*ByteWidth +: ByteWidth] <= wdata_i[b*ByteWidth +: ByteWidth];
         end
      end
      if (req_i && !we_i) rdata_q[0] <= mem_q[addr_i];
      for (int i = 1; i < Latency; i++) rdata_q[i] <= rdata_q[i-1];
   end

   assign rdata_o = rdata_q[Latency-1];

endmodule

// File: rtl/l2_ram_multi_bank_ctrl.sv
// Multi-bank L2 RAM: one TCDM slave port per bank, address range check with error
// responses, and a zero-fill engine that walks all banks after reset or on request.
module l2_ram_multi_bank_ctrl
   import l2_ram_pkg::*;
#(
   parameter int unsigned NB_BANKS      = 4,
   parameter int unsigned BANK_WORDS    = 32768,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned LATENCY       = 1,
   parameter logic [31:0] BASE_ADDR     = L2_IL_BASE_ADDR,
   parameter bit          INIT_ON_RESET = 1'b1,
   parameter logic [31:0] ERR_RDATA     = L2_ERR_RDATA
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NB_BANKS-1:0]            req_i,
   input  logic [NB_BANKS*32-1:0]         add_i,
   input  logic [NB_BANKS-1:0]            wen_i,
   input  logic [NB_BANKS*DATA_WIDTH-1:0] wdata_i,
   input  logic [NB_BANKS*DATA_WIDTH/8-1:0] be_i,
   output logic [NB_BANKS-1:0]            gnt_o,
   output logic [NB_BANKS-1:0]            r_valid_o,
   output logic [NB_BANKS*DATA_WIDTH-1:0] r_rdata_o,
   output logic [NB_BANKS-1:0]            r_opc_o,
   input  logic                           init_req_i,
   output logic                           init_busy_o,
   output logic                           init_done_o
);

   localparam int unsigned ADDR_W   = bank_aw(BANK_WORDS);
   localparam int unsigned SEL_BITS = sel_w(NB_BANKS);
   localparam int unsigned IDX_LO   = 2 + SEL_BITS;
   localparam int unsigned BE_W     = DATA_WIDTH / 8;
   localparam logic [63:0] REGION_BYTES = 64'(NB_BANKS) * 64'(BANK_WORDS) * 64'd4;
   localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_RDATA);

   l2_state_e           state_q;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                busy_q, done_q;
   logic [NB_BANKS-1:0] pipe_empty;
   logic                init_mode;

   assign cnt_d     = cnt_q + ADDR_W'(1);
   assign init_mode = (state_q == ST_INIT);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= INIT_ON_RESET ? ST_INIT : ST_RUN;
         cnt_q   <= '0;
         busy_q  <= INIT_ON_RESET;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (init_req_i) begin
                  state_q <= ST_DRAIN;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (&pipe_empty) state_q <= ST_INIT;
            end
            ST_INIT: begin
               if (cnt_q == ADDR_W'(BANK_WORDS - 1)) begin
                  cnt_q   <= '0;
                  state_q <= ST_RUN;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   // Requests are only accepted in RUN and never while reset is held.
   assign gnt_o       = (state_q == ST_RUN && !rst_i) ? req_i : '0;
   assign init_busy_o = busy_q & ~rst_i;
   assign init_done_o = done_q;

   for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
      logic [31:0]           off;
      logic                  addr_err;
      logic                  sram_req, sram_we;
      logic [ADDR_W-1:0]     sram_addr;
      logic [DATA_WIDTH-1:0] sram_wdata, sram_rdata;
      logic [BE_W-1:0]       sram_be;
      logic                  rsp_vld, rsp_err, rsp_rd;

      // Addresses below the base wrap to a large offset and fail the same check.
      assign off      = add_i[b*32 +: 32] - BASE_ADDR;
      assign addr_err = ({32'd0, off} >= REGION_BYTES);

      assign sram_req   = init_mode | (gnt_o[b] & ~addr_err);
      assign sram_we    = init_mode | ~wen_i[b];
      assign sram_addr  = init_mode ? cnt_q : off[IDX_LO +: ADDR_W];
      assign sram_wdata = init_mode ? '0 : wdata_i[b*DATA_WIDTH +: DATA_WIDTH];
      assign sram_be    = init_mode ? '1 : be_i[b*BE_W +: BE_W];

      tc_sram #(
         .NumWords  (BANK_WORDS),
         .DataWidth (DATA_WIDTH),
         .ByteWidth (8),
         .Latency   (LATENCY)
      ) i_sram (
         .clk_i   (clk_i),
         .req_i   (sram_req),
         .we_i    (sram_we),
         .addr_i  (sram_addr),
         .wdata_i (sram_wdata),
         .be_i    (sram_be),
         .rdata_o (sram_rdata)
      );

      l2_bank_resp_pipe #(
         .LATENCY (LATENCY)
      ) i_resp_pipe (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .valid_i   (gnt_o[b]),
         .err_i     (addr_err),
         .is_read_i (wen_i[b]),
         .valid_o   (rsp_vld),
         .err_o     (rsp_err),
         .is_read_o (rsp_rd),
         .empty_o   (pipe_empty[b])
      );

      assign r_valid_o[b] = rsp_vld;
      assign r_opc_o[b]   = rsp_vld & rsp_err;
      assign r_rdata_o[b*DATA_WIDTH +: DATA_WIDTH] =
         (!rsp_vld || !rsp_rd) ? '0 : (rsp_err ? ERR_DATA : sram_rdata);
   end

endmodule

// File: tb/tb_l2_ram_multi_bank_ctrl.sv
// Directed and randomized bench for l2_ram_multi_bank_ctrl against a cycle-indexed scoreboard.
module tb_l2_ram_multi_bank_ctrl;

   localparam int NB   = 4;
   localparam int BW   = 16;
   localparam int DW   = 32;
   localparam int LAT  = 3;
   localparam int RING = 8;
   localparam logic [31:0] BASE   = 32'h1C00_0000;
   localparam logic [31:0] ERRD   = 32'hBADA_CCE5;
   localparam logic [31:0] REGION = NB * BW * 4;

   logic              clk_i, rst_i;
   logic [NB-1:0]     req_i, wen_i, gnt_o, r_valid_o, r_opc_o;
   logic [NB*32-1:0]  add_i;
   logic [NB*DW-1:0]  wdata_i, r_rdata_o;
   logic [NB*DW/8-1:0] be_i;
   logic              init_req_i, init_busy_o, init_done_o;

   l2_ram_multi_bank_ctrl #(
      .NB_BANKS(NB), .BANK_WORDS(BW), .DATA_WIDTH(DW), .LATENCY(LAT),
      .BASE_ADDR(BASE), .INIT_ON_RESET(1'b1), .ERR_RDATA(ERRD)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
      .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
      .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o), .init_req_i(init_req_i),
      .init_busy_o(init_busy_o), .init_done_o(init_done_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // stimulus for the next cycle
   logic        s_req [NB];
   logic        s_wen [NB];
   logic [31:0] s_add [NB];
   logic [31:0] s_wdata [NB];
   logic [3:0]  s_be [NB];
   logic        s_init;

   // reference model: bank contents and expected responses indexed by due cycle
   logic [31:0] mem [NB][BW];
   logic        ev [NB][RING];
   logic        eo [NB][RING];
   logic [31:0] ed [NB][RING];
   int cyc, run_from, last_due;
   int n_cmp, n_mis;
   int n_rv [NB];
   int snap [NB];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] waddr(input int p, input int w);
      return BASE + 32'((w * NB + p) * 4);
   endfunction

   function automatic bit m_err(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off >= REGION;
   endfunction

   function automatic int m_word(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return int'((off / (4 * NB)) % BW);
   endfunction

   task automatic idle();
      for (int p = 0; p < NB; p++) begin
         s_req[p] = 1'b0; s_wen[p] = 1'b1; s_add[p] = '0; s_wdata[p] = '0; s_be[p] = '0;
      end
      s_init = 1'b0;
   endtask

   task automatic rd(input int p, input logic [31:0] a);
      s_req[p] = 1'b1; s_wen[p] = 1'b1; s_add[p] = a; s_wdata[p] = $urandom; s_be[p] = 4'($urandom);
   endtask

   task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      s_req[p] = 1'b1; s_wen[p] = 1'b0; s_add[p] = a; s_wdata[p] = d; s_be[p] = be;
   endtask

   task automatic drive();
      for (int p = 0; p < NB; p++) begin
         req_i[p] = s_req[p];
         wen_i[p] = s_wen[p];
         add_i[p*32 +: 32] = s_add[p];
         wdata_i[p*DW +: DW] = s_wdata[p];
         be_i[p*4 +: 4] = s_be[p];
      end
      init_req_i = s_init;
   endtask

   task automatic step();
      logic [NB-1:0] g_exp;
      int slot, w;
      logic [31:0] d;
      bit e;
      drive();
      @(negedge clk_i);
      g_exp = '0;
      for (int p = 0; p < NB; p++) if (s_req[p] && cyc >= run_from) g_exp[p] = 1'b1;
      chk($sformatf("gnt@%0d", cyc), 64'(gnt_o), 64'(g_exp));
      chk($sformatf("busy@%0d", cyc), 64'(init_busy_o), 64'(cyc < run_from));
      chk($sformatf("done@%0d", cyc), 64'(init_done_o), 64'(cyc >= run_from));
      slot = cyc % RING;
      for (int p = 0; p < NB; p++) begin
         chk($sformatf("rvalid[%0d]@%0d", p, cyc), 64'(r_valid_o[p]), 64'(ev[p][slot]));
         chk($sformatf("ropc[%0d]@%0d", p, cyc), 64'(r_opc_o[p]), 64'(eo[p][slot]));
         chk($sformatf("rdata[%0d]@%0d", p, cyc), 64'(r_rdata_o[p*DW +: DW]), 64'(ed[p][slot]));
         if (r_valid_o[p]) n_rv[p]++;
         ev[p][slot] = 1'b0; eo[p][slot] = 1'b0; ed[p][slot] = '0;
      end
      for (int p = 0; p < NB; p++) begin
         if (g_exp[p]) begin
            e = m_err(s_add[p]);
            w = m_word(s_add[p]);
            d = '0;
            if (e) begin
               if (s_wen[p]) d = ERRD;
            end else if (s_wen[p]) begin
               d = mem[p][w];
            end else begin
               for (int b = 0; b < 4; b++)
                  if (s_be[p][b]) mem[p][w][8*b +: 8] = s_wdata[p][8*b +: 8];
            end
            slot = (cyc + LAT) % RING;
            ev[p][slot] = 1'b1; eo[p][slot] = e; ed[p][slot] = d;
            if (cyc + LAT > last_due) last_due = cyc + LAT;
         end
      end
      if (s_init && cyc >= run_from) begin
         run_from = ((last_due + 1 > cyc + 1) ? last_due + 1 : cyc + 1) + BW + 1;
         for (int p = 0; p < NB; p++) for (int i = 0; i < BW; i++) mem[p][i] = '0;
      end
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   initial begin
      n_cmp = 0; n_mis = 0;
      for (int p = 0; p < NB; p++) begin
         n_rv[p] = 0;
         for (int i = 0; i < BW; i++) mem[p][i] = '0;
         for (int i = 0; i < RING; i++) begin ev[p][i] = 1'b0; eo[p][i] = 1'b0; ed[p][i] = '0; end
      end
      idle();
      for (int p = 0; p < NB; p++) rd(p, waddr(p, 0));
      rst_i = 1'b1;
      drive();

      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("rst_gnt", 64'(gnt_o), 64'd0);
      chk("rst_busy", 64'(init_busy_o), 64'd0);
      chk("rst_done", 64'(init_done_o), 64'd0);
      chk("rst_rvalid", 64'(r_valid_o), 64'd0);
      chk("rst_ropc", 64'(r_opc_o), 64'd0);
      chk("rst_rdata", 64'(r_rdata_o), 64'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      cyc = 1; run_from = 1 + BW; last_due = 0;

      // init after reset, requests held and a stray init_req that must be ignored
      for (int k = 0; k < BW + 2; k++) begin
         for (int p = 0; p < NB; p++) rd(p, waddr(p, k % BW));
         s_init = (k == 4);
         step();
      end
      idle();
      for (int w = 0; w < BW; w++) begin
         for (int p = 0; p < NB; p++) rd(p, waddr(p, w));
         step();
      end
      idle();
      for (int k = 0; k <= LAT; k++) step();

      // full write, readback, partial write, readback
      wr(0, BASE, 32'hDEAD_BEEF, 4'b1111); step();
      idle(); rd(0, BASE); step();
      idle(); wr(0, BASE, 32'h0000_AB00, 4'b0010); step();
      idle(); rd(0, BASE); step();
      idle();
      for (int k = 0; k <= LAT; k++) step();

      // out-of-range accesses, then confirm the error write left bank 1 intact
      rd(0, BASE + REGION);
      wr(1, BASE + REGION + 32'd4, 32'h1234_5678, 4'b1111);
      rd(2, BASE - 32'd8);
      rd(3, 32'hFFFF_FFFC);
      step();
      idle(); rd(1, waddr(1, 0)); step();
      idle();
      for (int k = 0; k <= LAT; k++) step();

      // random traffic, including unchecked bank bits and error addresses
      for (int k = 0; k < 80; k++) begin
         idle();
         for (int p = 0; p < NB; p++) begin
            if ($urandom_range(0, 3) != 0) begin
               logic [31:0] a;
               if ($urandom_range(0, 7) == 0)
                  a = ($urandom_range(0, 1) == 0) ? BASE + REGION + 32'(4 * $urandom_range(0, 63))
                                                  : BASE - 32'(4 * $urandom_range(1, 64));
               else
                  a = BASE + 32'(($urandom_range(0, BW-1) * NB + $urandom_range(0, NB-1)) * 4);
               if ($urandom_range(0, 1) == 0) rd(p, a);
               else wr(p, a, $urandom, 4'($urandom));
            end
         end
         step();
      end
      idle();
      for (int k = 0; k <= LAT; k++) step();

      // scrub request with three reads in flight
      wr(0, waddr(0, 3), 32'hCAFE_F00D, 4'b1111); step();
      idle(); rd(0, waddr(0, 3)); step();
      rd(0, waddr(0, 4)); step();
      rd(0, waddr(0, 3)); s_init = 1'b1; step();
      idle();
      for (int k = 0; k < LAT + BW + 4; k++) begin
         rd(3, waddr(3, 1));
         step();
      end
      idle();
      rd(0, waddr(0, 3)); rd(2, waddr(2, 7)); step();
      idle();
      for (int k = 0; k <= LAT; k++) step();

      // all ports streaming reads every cycle
      for (int p = 0; p < NB; p++) snap[p] = n_rv[p];
      for (int k = 0; k < 100; k++) begin
         for (int p = 0; p < NB; p++) rd(p, waddr(p, $urandom_range(0, BW-1)));
         step();
      end
      idle();
      for (int k = 0; k <= LAT; k++) step();
      for (int p = 0; p < NB; p++)
         chk($sformatf("stream_count[%0d]", p), 64'(n_rv[p] - snap[p]), 64'd100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
